// File: rtl/set_assoc_wb_cache.sv
// set_assoc_wb_cache
//   Set-associative, write-back, write-allocate data cache. It sits between a
//   64-bit load/store port and a line-wide memory port. On a miss, a dirty
//   victim is written back first, then the line is refilled. Each set keeps
//   its own round-robin replacement pointer.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   IDLE      | p_ready=1, a request is latched when p_read_en|p_write_en
//   LOOKUP    | tag compare; a hit completes here, a miss picks a victim
//   WRITEBACK | dirty victim on the memory port, waiting for m_ack
//   REFILL    | line read on the memory port, waiting for m_ack
//   RESPOND   | filled line is resident, complete the access
//
// Ports
//   clk, rst               clock; asynchronous active-low reset
//   p_addr, p_write_data   processor byte address (bits [2:0] ignored), store data
//   p_read_en, p_write_en  load / store request (both set = store)
//   p_ready                idle, a request is sampled this cycle
//   p_done, p_read_data    completion pulse, load data
//   hit, miss              lookup outcome pulses
//   m_addr, m_write_data   line-aligned memory address, victim line
//   m_read_en, m_write_en  refill / write-back request, held until m_ack
//   m_read_data, m_ack     refill line, memory completion
//
// All outputs except p_ready are registered. A pulse or value decided in a
// state becomes visible on the cycle after that state.
module set_assoc_wb_cache #(
    parameter int unsigned ASSOCIATIVITY = 8,
    parameter int unsigned NUM_SETS      = 64,
    parameter int unsigned BLOCK_SIZE    = 64,
    parameter int unsigned ADDR_WIDTH    = 64,
    localparam int unsigned LINE_W       = BLOCK_SIZE * 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] p_addr,
    input  logic [63:0]           p_write_data,
    input  logic                  p_read_en,
    input  logic                  p_write_en,
    output logic                  p_ready,
    output logic                  p_done,
    output logic [63:0]           p_read_data,
    output logic                  hit,
    output logic                  miss,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [LINE_W-1:0]     m_write_data,
    output logic                  m_read_en,
    output logic                  m_write_en,
    input  logic [LINE_W-1:0]     m_read_data,
    input  logic                  m_ack
);
    localparam int unsigned INDEX_W  = $clog2(NUM_SETS);
    localparam int unsigned OFFSET_W = $clog2(BLOCK_SIZE);
    localparam int unsigned TAG_W    = ADDR_WIDTH - INDEX_W - OFFSET_W;
    localparam int unsigned WAY_W    = (ASSOCIATIVITY > 1) ? $clog2(ASSOCIATIVITY) : 1;
    localparam int unsigned WSEL_W   = (OFFSET_W > 3) ? OFFSET_W - 3 : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WRITEBACK, S_REFILL, S_RESPOND} state_t;

    state_t state_q, state_d;

    logic [NUM_SETS-1:0][ASSOCIATIVITY-1:0] valid_q, dirty_q;
    logic [NUM_SETS-1:0][WAY_W-1:0]         rr_q;
    logic [TAG_W-1:0]  tag_q  [NUM_SETS][ASSOCIATIVITY];
    logic [LINE_W-1:0] data_q [NUM_SETS][ASSOCIATIVITY];

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [63:0]           wdata_q, wdata_d;
    logic                  is_store_q, is_store_d;
    logic [WAY_W-1:0]      victim_q, victim_d;
    logic                  by_ptr_q, by_ptr_d;

    logic                  p_done_q, p_done_d, hit_q, hit_d, miss_q, miss_d;
    logic [63:0]           p_read_data_q, p_read_data_d;
    logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
    logic [LINE_W-1:0]     m_write_data_q, m_write_data_d;
    logic                  m_read_en_q, m_read_en_d, m_write_en_q, m_write_en_d;

    logic [INDEX_W-1:0]    idx;
    logic [TAG_W-1:0]      tag;
    logic [WSEL_W-1:0]     wsel;
    logic                  hit_any, inv_any, victim_dirty;
    logic [WAY_W-1:0]      hit_way, inv_way, victim, rr_next;
    logic [LINE_W-1:0]     hit_line, resp_line, refill_line;
    logic [ADDR_WIDTH-1:0] refill_addr;

    assign idx         = addr_q[OFFSET_W +: INDEX_W];
    assign tag         = addr_q[ADDR_WIDTH-1 -: TAG_W];
    assign wsel        = WSEL_W'(addr_q[OFFSET_W-1:0] >> 3);
    assign refill_addr = {addr_q[ADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
    assign hit_line    = data_q[idx][hit_way];
    assign resp_line   = data_q[idx][victim_q];
    assign rr_next     = (ASSOCIATIVITY == 1) ? '0 : WAY_W'(rr_q[idx] + 1'b1);

    // Tag compare across the set and victim choice: the lowest invalid way
    // wins, otherwise the set's round-robin pointer.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        for (int w = 0; w < int'(ASSOCIATIVITY); w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        for (int w = int'(ASSOCIATIVITY) - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
        victim       = inv_any ? inv_way : rr_q[idx];
        victim_dirty = valid_q[idx][victim] && dirty_q[idx][victim];
    end

    // A store miss merges its word into the incoming line, so that one write
    // fills the line.
    always_comb begin
        refill_line = m_read_data;
        if (is_store_q) refill_line[int'(wsel)*64 +: 64] = wdata_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            is_store_q     <= 1'b0;
            victim_q       <= '0;
            by_ptr_q       <= 1'b0;
            p_done_q       <= 1'b0;
            hit_q          <= 1'b0;
            miss_q         <= 1'b0;
            p_read_data_q  <= '0;
            m_addr_q       <= '0;
            m_write_data_q <= '0;
            m_read_en_q    <= 1'b0;
            m_write_en_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            is_store_q     <= is_store_d;
            victim_q       <= victim_d;
            by_ptr_q       <= by_ptr_d;
            p_done_q       <= p_done_d;
            hit_q          <= hit_d;
            miss_q         <= miss_d;
            p_read_data_q  <= p_read_data_d;
            m_addr_q       <= m_addr_d;
            m_write_data_q <= m_write_data_d;
            m_read_en_q    <= m_read_en_d;
            m_write_en_q   <= m_write_en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:      if (p_read_en || p_write_en) state_d = S_LOOKUP;
            S_LOOKUP:    state_d = hit_any ? S_IDLE : (victim_dirty ? S_WRITEBACK : S_REFILL);
            S_WRITEBACK: if (m_ack) state_d = S_REFILL;
            S_REFILL:    if (m_ack) state_d = S_RESPOND;
            S_RESPOND:   state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        is_store_d     = is_store_q;
        victim_d       = victim_q;
        by_ptr_d       = by_ptr_q;
        p_done_d       = 1'b0;
        hit_d          = 1'b0;
        miss_d         = 1'b0;
        p_read_data_d  = p_read_data_q;
        m_addr_d       = m_addr_q;
        m_write_data_d = m_write_data_q;
        m_read_en_d    = m_read_en_q;
        m_write_en_d   = m_write_en_q;
        unique case (state_q)
            S_IDLE: begin
                if (p_read_en || p_write_en) begin
                    addr_d     = p_addr;
                    wdata_d    = p_write_data;
                    is_store_d = p_write_en;
                end
            end
            S_LOOKUP: begin
                if (hit_any) begin
                    hit_d    = 1'b1;
                    p_done_d = 1'b1;
                    if (!is_store_q) p_read_data_d = hit_line[int'(wsel)*64 +: 64];
                end else begin
                    miss_d   = 1'b1;
                    victim_d = victim;
                    by_ptr_d = !inv_any;
                    if (victim_dirty) begin
                        m_addr_d       = {tag_q[idx][victim], idx, {OFFSET_W{1'b0}}};
                        m_write_data_d = data_q[idx][victim];
                        m_write_en_d   = 1'b1;
                    end else begin
                        m_addr_d    = refill_addr;
                        m_read_en_d = 1'b1;
                    end
                end
            end
            S_WRITEBACK: begin
                if (m_ack) begin
                    m_write_en_d = 1'b0;
                    m_addr_d     = refill_addr;
                    m_read_en_d  = 1'b1;
                end
            end
            S_REFILL: begin
                if (m_ack) m_read_en_d = 1'b0;
            end
            S_RESPOND: begin
                p_done_d = 1'b1;
                if (!is_store_q) p_read_data_d = resp_line[int'(wsel)*64 +: 64];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            dirty_q <= '0;
            rr_q    <= '0;
        end else begin
            if (state_q == S_LOOKUP && hit_any && is_store_q) dirty_q[idx][hit_way] <= 1'b1;
            if (state_q == S_REFILL && m_ack) begin
                valid_q[idx][victim_q] <= 1'b1;
                dirty_q[idx][victim_q] <= is_store_q;
                if (by_ptr_q) rr_q[idx] <= rr_next;
            end
        end
    end

    // Line payload and tags carry no reset; valid bits qualify them.
    always_ff @(posedge clk) begin
        if (state_q == S_LOOKUP && hit_any && is_store_q)
            data_q[idx][hit_way][int'(wsel)*64 +: 64] <= wdata_q;
        if (state_q == S_REFILL && m_ack) begin
            data_q[idx][victim_q] <= refill_line;
            tag_q[idx][victim_q]  <= tag;
        end
    end

    assign p_ready      = (state_q == S_IDLE);
    assign p_done       = p_done_q;
    assign hit          = hit_q;
    assign miss         = miss_q;
    assign p_read_data  = p_read_data_q;
    assign m_addr       = m_addr_q;
    assign m_write_data = m_write_data_q;
    assign m_read_en    = m_read_en_q;
    assign m_write_en   = m_write_en_q;
endmodule

// File: tb/tb_set_assoc_wb_cache.sv
// Directed bench for set_assoc_wb_cache with default parameters
// (index = addr[11:6], tag = addr[63:12], 64-byte lines).
module tb_set_assoc_wb_cache;
    logic         clk = 1'b0;
    logic         rst;
    logic [63:0]  p_addr, p_write_data, p_read_data, m_addr;
    logic         p_read_en, p_write_en, p_ready, p_done, hit, miss;
    logic [511:0] m_write_data, m_read_data;
    logic         m_read_en, m_write_en, m_ack;

    int n_cmp = 0;
    int n_err = 0;

    set_assoc_wb_cache dut (
        .clk(clk), .rst(rst),
        .p_addr(p_addr), .p_write_data(p_write_data),
        .p_read_en(p_read_en), .p_write_en(p_write_en),
        .p_ready(p_ready), .p_done(p_done), .p_read_data(p_read_data),
        .hit(hit), .miss(miss),
        .m_addr(m_addr), .m_write_data(m_write_data),
        .m_read_en(m_read_en), .m_write_en(m_write_en),
        .m_read_data(m_read_data), .m_ack(m_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] mk_line(input logic [63:0] seed);
        logic [511:0] l;
        for (int k = 0; k < 8; k++) l[k*64 +: 64] = seed + 64'(k);
        return l;
    endfunction

    // Issue one request from IDLE; returns at the negedge after the lookup
    // result is registered (hit/miss/p_done and first m_* request visible).
    task automatic do_req(input logic [63:0] a, input logic [63:0] d, input logic r, input logic w);
        @(negedge clk);
        p_addr = a; p_write_data = d; p_read_en = r; p_write_en = w;
        @(negedge clk);
        p_read_en = 1'b0; p_write_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic mem_ack(input logic [511:0] line, input int delay);
        repeat (delay) @(negedge clk);
        m_read_data = line;
        m_ack = 1'b1;
        @(negedge clk);
        m_ack = 1'b0;
    endtask

    task automatic wait_done(input string tag, output logic [63:0] rdata);
        logic found;
        found = 1'b0;
        rdata = '0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (p_done) begin
                found = 1'b1;
                rdata = p_read_data;
            end
        end
        check(tag, 64'(found), 64'd1);
    endtask

    initial begin
        logic [63:0]  rd;
        logic [511:0] line;
        logic         seen;

        rst = 1'b0; p_addr = '0; p_write_data = '0; p_read_en = 1'b0; p_write_en = 1'b0;
        m_read_data = '0; m_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_p_ready", 64'(p_ready), 64'd1);
        check("rst_p_done", 64'(p_done), 64'd0);
        check("rst_hit", 64'(hit), 64'd0);
        check("rst_miss", 64'(miss), 64'd0);
        check("rst_m_read_en", 64'(m_read_en), 64'd0);
        check("rst_m_write_en", 64'(m_write_en), 64'd0);
        check("rst_m_addr", m_addr, 64'd0);
        check("rst_p_read_data", p_read_data, 64'd0);
        check("rst_m_write_data", m_write_data[63:0], 64'd0);
        rst = 1'b1;

        // 1: cold load miss, refill, then hit
        do_req(64'h1008, 64'd0, 1'b1, 1'b0);
        check("t1_miss", 64'(miss), 64'd1);
        check("t1_hit", 64'(hit), 64'd0);
        check("t1_m_read_en", 64'(m_read_en), 64'd1);
        check("t1_m_write_en", 64'(m_write_en), 64'd0);
        check("t1_m_addr", m_addr, 64'h1000);
        check("t1_p_ready", 64'(p_ready), 64'd0);
        line = mk_line(64'hA000);
        line[127:64] = 64'h1111_2222_3333_4444;
        mem_ack(line, 3);
        check("t1_m_read_en_drop", 64'(m_read_en), 64'd0);
        wait_done("t1_done", rd);
        check("t1_data", rd, 64'h1111_2222_3333_4444);
        do_req(64'h1008, 64'd0, 1'b1, 1'b0);
        check("t1_rehit", 64'(hit), 64'd1);
        check("t1_rehit_done", 64'(p_done), 64'd1);
        check("t1_rehit_data", p_read_data, 64'h1111_2222_3333_4444);
        check("t1_rehit_no_mem", 64'(m_read_en | m_write_en), 64'd0);

        // 2: store hit then load back
        do_req(64'h1010, 64'hDEAD, 1'b0, 1'b1);
        check("t2_store_hit", 64'(hit), 64'd1);
        check("t2_store_done", 64'(p_done), 64'd1);
        check("t2_no_mem", 64'(m_read_en | m_write_en), 64'd0);
        do_req(64'h1010, 64'd0, 1'b1, 1'b0);
        check("t2_load_hit", 64'(hit), 64'd1);
        check("t2_load_data", p_read_data, 64'hDEAD);

        // 3: store miss with word merge
        do_req(64'h2038, 64'h55, 1'b0, 1'b1);
        check("t3_miss", 64'(miss), 64'd1);
        check("t3_m_addr", m_addr, 64'h2000);
        check("t3_m_read_en", 64'(m_read_en), 64'd1);
        mem_ack(mk_line(64'h2000_0000), 1);
        wait_done("t3_done", rd);
        do_req(64'h2038, 64'd0, 1'b1, 1'b0);
        check("t3_load_hit", 64'(hit), 64'd1);
        check("t3_load_data", p_read_data, 64'h55);
        do_req(64'h2030, 64'd0, 1'b1, 1'b0);
        check("t3_neighbour", p_read_data, 64'h2000_0006);

        // 4: fresh cache, fill set 0, dirty-victim eviction
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            do_req(64'(i) << 12, 64'd0, 1'b1, 1'b0);
            check($sformatf("t4_fill%0d_miss", i), 64'(miss), 64'd1);
            check($sformatf("t4_fill%0d_addr", i), m_addr, 64'(i) << 12);
            mem_ack(mk_line(64'(i) << 32), 1);
            wait_done($sformatf("t4_fill%0d_done", i), rd);
            check($sformatf("t4_fill%0d_data", i), rd, 64'(i) << 32);
        end
        do_req(64'h0000, 64'hCAFE, 1'b0, 1'b1);
        check("t4_store_hit", 64'(hit), 64'd1);
        do_req(64'h8000, 64'd0, 1'b1, 1'b0);
        check("t4_evict_miss", 64'(miss), 64'd1);
        check("t4_wb_en", 64'(m_write_en), 64'd1);
        check("t4_wb_no_rd", 64'(m_read_en), 64'd0);
        check("t4_wb_addr", m_addr, 64'h0000);
        check("t4_wb_word0", m_write_data[63:0], 64'hCAFE);
        check("t4_wb_word1", m_write_data[127:64], 64'd1);
        line = mk_line(64'h8888_0000_0000_0000);
        mem_ack(line, 2);
        check("t4_wb_drop", 64'(m_write_en), 64'd0);
        check("t4_rf_en", 64'(m_read_en), 64'd1);
        check("t4_rf_addr", m_addr, 64'h8000);
        mem_ack(line, 1);
        wait_done("t4_evict_done", rd);
        check("t4_evict_data", rd, 64'h8888_0000_0000_0000);
        do_req(64'h9000, 64'd0, 1'b1, 1'b0);
        check("t4_9000_miss", 64'(miss), 64'd1);
        check("t4_9000_no_wb", 64'(m_write_en), 64'd0);
        check("t4_9000_addr", m_addr, 64'h9000);
        mem_ack(mk_line(64'h9999_0000_0000_0000), 0);
        wait_done("t4_9000_done", rd);
        check("t4_9000_data", rd, 64'h9999_0000_0000_0000);
        do_req(64'h1000, 64'd0, 1'b1, 1'b0);
        check("t4_way1_replaced", 64'(miss), 64'd1);
        check("t4_1000_no_wb", 64'(m_write_en), 64'd0);
        mem_ack(mk_line(64'h1000_0000_0000), 1);
        wait_done("t4_1000_done", rd);
        check("t4_1000_data", rd, 64'h1000_0000_0000);
        do_req(64'h8008, 64'd0, 1'b1, 1'b0);
        check("t4_8000_hit", 64'(hit), 64'd1);
        check("t4_8000_data", p_read_data, 64'h8888_0000_0000_0001);

        // 5: reset while REFILL waits
        do_req(64'h0040, 64'd0, 1'b1, 1'b0);
        check("t5_miss", 64'(miss), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5_rd_drop", 64'(m_read_en), 64'd0);
        check("t5_ready", 64'(p_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen |= p_done;
        end
        check("t5_no_done", 64'(seen), 64'd0);
        do_req(64'h8000, 64'd0, 1'b1, 1'b0);
        check("t5_was_hit_now_miss", 64'(miss), 64'd1);
        mem_ack(line, 1);
        wait_done("t5_done", rd);
        check("t5_data", rd, 64'h8888_0000_0000_0000);

        // 6: both enables = store; stalled memory blocks new requests
        do_req(64'h5008, 64'h77, 1'b1, 1'b1);
        check("t6_miss", 64'(miss), 64'd1);
        check("t6_m_addr", m_addr, 64'h5000);
        seen = 1'b0;
        repeat (10) begin
            p_addr = 64'h8008; p_read_en = 1'b1;
            @(negedge clk);
            seen |= p_ready | p_done | hit;
        end
        p_read_en = 1'b0;
        check("t6_stall_quiet", 64'(seen), 64'd0);
        check("t6_rd_held", 64'(m_read_en), 64'd1);
        mem_ack(mk_line(64'h5555_0000_0000_0000), 0);
        wait_done("t6_done", rd);
        check("t6_rdata_held", rd, 64'h8888_0000_0000_0000);
        do_req(64'h5008, 64'd0, 1'b1, 1'b0);
        check("t6_hit", 64'(hit), 64'd1);
        check("t6_merged", p_read_data, 64'h77);
        do_req(64'h5000, 64'd0, 1'b1, 1'b0);
        check("t6_word0", p_read_data, 64'h5555_0000_0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/set_assoc_wb_cache.md
Name: set_assoc_wb_cache

Overview:
Parametrised set-associative, write-back, write-allocate data cache between the core's 64-bit load/store port and the line-wide memory port. It replaces the single-cycle blocking lookup with a proper controller:
- explicit request/done handshake on the processor side;
- request/acknowledge handshake on the memory side;
- dirty-victim write-back before refill;
- per-set round-robin replacement.

Parameters:
ASSOCIATIVITY, 8, ways per set (power of 2, >=1)
NUM_SETS, 64, sets (power of 2, >=2)
BLOCK_SIZE, 64, line size in bytes (power of 2, >=8); LINE_W = BLOCK_SIZE*8
ADDR_WIDTH, 64, byte-address width; INDEX_W = clog2(NUM_SETS), OFFSET_W = clog2(BLOCK_SIZE), TAG_W = ADDR_WIDTH-INDEX_W-OFFSET_W

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
p_addr  in  ADDR_WIDTH  byte address; bits [2:0] ignored (64-bit word access)
p_write_data  in  64  store data
p_read_en  in  1  load request
p_write_en  in  1  store request
p_ready  out  1  cache idle, request sampled this cycle
p_done  out  1  one-cycle pulse, access complete
p_read_data  out  64  load data, valid with p_done on loads
hit  out  1  one-cycle pulse, lookup hit
miss  out  1  one-cycle pulse, lookup miss
m_addr  out  ADDR_WIDTH  line-aligned memory address (offset bits zero)
m_write_data  out  LINE_W  victim line for write-back
m_read_en  out  1  refill request, held until m_ack
m_write_en  out  1  write-back request, held until m_ack
m_read_data  in  LINE_W  refill line, sampled on m_ack
m_ack  in  1  memory completes the current request this cycle

Behaviour:
- Reset (rst=0, async):
  - all valid and dirty bits cleared; round-robin pointers cleared;
  - state returns to IDLE;
  - p_done, hit, miss, m_read_en, m_write_en = 0;
  - p_read_data, m_addr, m_write_data = 0;
  - p_ready = 1.
  - Reset mid-operation abandons the transaction immediately and drops m_read_en/m_write_en in the same cycle.
- States: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND.
- IDLE:
  - p_ready=1. If p_read_en|p_write_en, latch address, data and op, then go to LOOKUP.
  - Both enables asserted together = store; p_read_data is not updated.
- LOOKUP (cycle after acceptance), p_ready=0. Compare the tag against all valid ways of the indexed set.
  - Hit: pulse hit and p_done this cycle.
    - Load: p_read_data = line word p_addr[OFFSET_W-1:3].
    - Store: write that word and set the dirty bit.
    - Next state IDLE. Hit latency = 1 cycle after acceptance.
  - Miss: pulse miss.
    - Victim = lowest-index invalid way; else the set's round-robin pointer.
    - Victim valid and dirty: m_addr = {victim tag, index, 0}, m_write_data = victim line, m_write_en=1, go to WRITEBACK.
    - Otherwise: m_addr = {tag, index, 0}, m_read_en=1, go to REFILL.
- WRITEBACK: hold outputs until m_ack. On m_ack: clear m_write_en, set m_addr to the refill address, set m_read_en=1, go to REFILL.
- REFILL: hold until m_ack. On m_ack:
  - write m_read_data into the victim way; set valid; write tag;
  - clear m_read_en;
  - store: merge p_write_data into the addressed word and set dirty=1; load: dirty=0;
  - if the victim was chosen by pointer, advance that set's pointer (mod ASSOCIATIVITY);
  - go to RESPOND.
- RESPOND: pulse p_done.
  - Load: p_read_data = addressed word of the filled line.
  - Go to IDLE.
- m_ack outside WRITEBACK/REFILL is ignored. m_read_en and m_write_en are never both 1.
- Requests while p_ready=0 are ignored; the core must hold or re-issue.
- p_read_data holds its last value between loads.
- Storage is NUM_SETS x ASSOCIATIVITY; no index wrap beyond NUM_SETS-1.

Test Plan (defaults: index = addr[11:6], tag = addr[63:12]):
1. After reset, load 0x1008:
   - required: miss pulse, m_read_en=1, m_addr=0x1000;
   - ack after 3 cycles with word1 = 0x1111_2222_3333_4444 -> p_done with that data;
   - load 0x1008 again -> hit and p_done 1 cycle after acceptance, no m_* activity.
2. Store 0x1010 = 0xDEAD on a resident line -> hit pulse, no memory traffic; load 0x1010 -> 0xDEAD.
3. Store miss 0x2038 = 0x55:
   - required: refill from 0x2000, word7 merged, line dirty;
   - load 0x2038 -> hit, 0x55.
4. Dirty-victim eviction:
   - stimulus: fill set 0 with 0x0000..0x7000, store to 0x0000, then load 0x8000;
   - required: m_write_en with m_addr=0x0000 and the stored word in m_write_data, then m_read_en at 0x8000, way 0 replaced;
   - load 0x9000 -> no write-back (way 1 clean), way 1 replaced.
5. rst pulled low while REFILL waits for m_ack:
   - required: m_read_en=0 immediately, p_ready=1, no p_done;
   - a previously hit address now misses.
6. Simultaneous p_read_en=p_write_en=1 with data 0x77 -> treated as store; m_ack held low 10 cycles -> p_ready stays 0 and new requests are ignored.
